// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types and default sizes for the crossbar arbiter
// Purpose: per-input request FSM state type and default port/payload sizes.
// Ports: none (package).
package xbar_pkg;

  localparam int XBAR_NUM_PORTS = 4;
  localparam int XBAR_DATA_W    = 16;

  typedef enum logic [1:0] {
    IN_IDLE   = 2'd0,
    IN_ACTIVE = 2'd1,
    IN_DONE   = 2'd2
  } in_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
// Purpose: grants the first requester found at ptr_i+1, ptr_i+2, ... modulo N.
// Ports:
//   req_i  [N]  request vector
//   ptr_i  [W]  index of the previous winner
//   gnt_o  [N]  one-hot grant, all zero when no request is present
//   idx_o  [W]  index of the granted requester (0 when none)
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  int           cand;
  logic [W-1:0] cand_idx;
  logic         found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Walk the ring once, beginning just after the previous winner.
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/xbar_arbiter.sv
// rtl/xbar_arbiter.sv - NUM_PORTS x NUM_PORTS crossbar with per-output round-robin slots
// Purpose: each input captures a target mask and payload, then every targeted
//   output slot pulls the payload when it wins arbitration; the input pulses
//   req_ready once all its targets have been served.
// Config: define XBAR_MULTICAST_EN to serve the whole mask; otherwise only the
//   lowest set bit of the mask is kept.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     [N]        input i presents a request
//   req_target    [N*N]      target-output mask of input i
//   req_data      [N*DATA_W] payload of input i
//   req_ready     [N]        one-cycle pulse: request of input i delivered
//   out_valid     [N]        output slot j holds a payload
//   out_data      [N*DATA_W] payload of slot j
//   out_src       [N*PTR_W]  input index that produced slot j
//   out_ready     [N]        sink consumes slot j this cycle
module xbar_arbiter
  import xbar_pkg::*;
#(
  parameter  int NUM_PORTS = XBAR_NUM_PORTS,
  parameter  int DATA_W    = XBAR_DATA_W,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req_target,
  input  logic [NUM_PORTS*DATA_W-1:0]    req_data,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]    out_data,
  output logic [NUM_PORTS*PTR_W-1:0]     out_src,
  input  logic [NUM_PORTS-1:0]           out_ready
);

  // Reset pointer value makes input 0 the first candidate after reset.
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);

  in_state_e            state_q [NUM_PORTS];
  in_state_e            state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_d  [NUM_PORTS];
  logic [DATA_W-1:0]    data_q  [NUM_PORTS];
  logic [DATA_W-1:0]    data_d  [NUM_PORTS];

  logic [NUM_PORTS-1:0] ovalid_q;
  logic [NUM_PORTS-1:0] ovalid_d;
  logic [DATA_W-1:0]    odata_q [NUM_PORTS];
  logic [DATA_W-1:0]    odata_d [NUM_PORTS];
  logic [PTR_W-1:0]     osrc_q  [NUM_PORTS];
  logic [PTR_W-1:0]     osrc_d  [NUM_PORTS];
  logic [PTR_W-1:0]     rr_q    [NUM_PORTS];
  logic [PTR_W-1:0]     rr_d    [NUM_PORTS];

  // arb_req/arb_gnt are indexed [output][input]; taken is [input][output].
  logic [NUM_PORTS-1:0] arb_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  logic [PTR_W-1:0]     arb_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] taken   [NUM_PORTS];
  logic [NUM_PORTS-1:0] slot_free;
  logic [NUM_PORTS-1:0] tgt;

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      arb_req[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_req[j][i] = (state_q[i] == IN_ACTIVE) && pend_q[i][j];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
      .req_i (arb_req[g]),
      .ptr_i (rr_q[g]),
      .gnt_o (arb_gnt[g]),
      .idx_o (arb_idx[g])
    );

    assign out_data[g*DATA_W +: DATA_W] = odata_q[g];
    assign out_src[g*PTR_W +: PTR_W]    = osrc_q[g];
    assign req_ready[g]                 = (state_q[g] == IN_DONE);
  end

  assign out_valid = ovalid_q;

  // A grant only takes effect when the slot can accept a new payload.
  always_comb begin
    slot_free = ~ovalid_q | out_ready;
    for (int i = 0; i < NUM_PORTS; i++) begin
      taken[i] = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        taken[i][j] = slot_free[j] & arb_gnt[j][i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    data_d   = data_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    osrc_d   = osrc_q;
    rr_d     = rr_q;
    tgt      = '0;

    // Output slots: reload on a win (back-to-back when consumed), else drain.
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (slot_free[j]) begin
        if (|arb_gnt[j]) begin
          ovalid_d[j] = 1'b1;
          odata_d[j]  = data_q[arb_idx[j]];
          osrc_d[j]   = arb_idx[j];
          rr_d[j]     = arb_idx[j];
        end else begin
          ovalid_d[j] = 1'b0;
        end
      end
    end

    // Input FSMs.
    for (int i = 0; i < NUM_PORTS; i++) begin
      case (state_q[i])
        IN_IDLE: begin
          if (req_valid[i]) begin
            tgt = req_target[i*NUM_PORTS +: NUM_PORTS];
`ifndef XBAR_MULTICAST_EN
            // Two's-complement trick isolates the lowest set bit.
            tgt = tgt & (-tgt);
`endif
            pend_d[i]  = tgt;
            data_d[i]  = req_data[i*DATA_W +: DATA_W];
            state_d[i] = (tgt == '0) ? IN_DONE : IN_ACTIVE;
          end
        end
        IN_ACTIVE: begin
          pend_d[i] = pend_q[i] & ~taken[i];
          if (pend_d[i] == '0) begin
            state_d[i] = IN_DONE;
          end
        end
        IN_DONE: begin
          state_d[i] = IN_IDLE;
        end
        default: begin
          state_d[i] = IN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        state_q[k] <= IN_IDLE;
        pend_q[k]  <= '0;
        data_q[k]  <= '0;
        odata_q[k] <= '0;
        osrc_q[k]  <= '0;
        rr_q[k]    <= PTR_RST;
      end
      ovalid_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      osrc_q   <= osrc_d;
      rr_q     <= rr_d;
    end
  end

endmodule

// File: tb/tb_xbar_arbiter.sv
// tb/tb_xbar_arbiter.sv - directed and randomized self-checking bench for xbar_arbiter
module tb_xbar_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PW = 2;

`ifdef XBAR_MULTICAST_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*N-1:0]  req_target;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    out_valid;
  logic [N*DW-1:0] out_data;
  logic [N*PW-1:0] out_src;
  logic [N-1:0]    out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  xbar_arbiter #(.NUM_PORTS(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ov();
    return 32'(out_valid);
  endfunction
  function automatic logic [31:0] rdy();
    return 32'(req_ready);
  endfunction
  function automatic logic [31:0] src_of(input int j);
    return 32'(out_src[j*PW +: PW]);
  endfunction
  function automatic logic [31:0] data_of(input int j);
    return 32'(out_data[j*DW +: DW]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_target = '0;
    req_data   = '0;
  endtask

  task automatic post(input int i, input logic [N-1:0] tgt, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_target[i*N +: N]  = tgt;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = '1;
    repeat (4) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    out_ready = '1;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Reference model: transaction view of inputs and output slots.
  int              m_busy [N];
  int              m_done [N];
  int              m_pend [N][N];
  logic [DW-1:0]   m_data [N];
  int              s_v    [N];
  logic [DW-1:0]   s_d    [N];
  int              s_src  [N];
  int              s_last [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
      m_data[i] = '0;
      for (int j = 0; j < N; j++) m_pend[i][j] = 0;
      s_v[i]    = 0;
      s_d[i]    = '0;
      s_src[i]  = 0;
      s_last[i] = N - 1;
    end
  endtask

  task automatic model_compare();
    for (int i = 0; i < N; i++) begin
      check("rnd_req_ready", 32'(req_ready[i]), m_done[i]);
      check("rnd_out_valid", 32'(out_valid[i]), s_v[i]);
      if (s_v[i] != 0) begin
        check("rnd_out_data", data_of(i), 32'(s_d[i]));
        check("rnd_out_src", src_of(i), s_src[i]);
      end
    end
  endtask

  // Advances the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int g_in [N];
    int c;
    int left;
    int first;
    for (int j = 0; j < N; j++) begin
      g_in[j] = -1;
      if (s_v[j] == 0 || out_ready[j]) begin
        for (int k = 1; k <= N; k++) begin
          c = (s_last[j] + k) % N;
          if (g_in[j] < 0 && m_busy[c] != 0 && m_pend[c][j] != 0) g_in[j] = c;
        end
        if (g_in[j] >= 0) begin
          s_v[j]    = 1;
          s_d[j]    = m_data[g_in[j]];
          s_src[j]  = g_in[j];
          s_last[j] = g_in[j];
        end else begin
          s_v[j] = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_done[i] != 0) begin
        m_done[i] = 0;
      end else if (m_busy[i] != 0) begin
        left = 0;
        for (int j = 0; j < N; j++) begin
          if (g_in[j] == i) m_pend[i][j] = 0;
          left += m_pend[i][j];
        end
        if (left == 0) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end else if (req_valid[i]) begin
        left  = 0;
        first = -1;
        for (int j = 0; j < N; j++) begin
          m_pend[i][j] = 0;
          if (req_target[i*N + j]) begin
            if (MC || first < 0) begin
              m_pend[i][j] = 1;
              left++;
            end
            if (first < 0) first = j;
          end
        end
        m_data[i] = req_data[i*DW +: DW];
        if (left == 0) m_done[i] = 1;
        else m_busy[i] = 1;
      end
    end
  endtask

  initial begin
    idle_inputs();
    out_ready = '1;
    rst_n     = 1'b0;
    repeat (2) step();
    check("rst_out_valid", ov(), 0);
    check("rst_req_ready", rdy(), 0);
    check("rst_out_data", 32'(out_data[31:0]), 0);
    check("rst_out_src", 32'(out_src), 0);
    rst_n = 1'b1;
    step();

    // Unicast
    post(0, 4'b0100, 16'hA5A5);
    check("uni_c0_rdy", rdy(), 0);
    step();
    idle_inputs();
    check("uni_c1_ov", ov(), 0);
    step();
    check("uni_c2_ov", ov(), 'b0100);
    check("uni_c2_data", data_of(2), 'hA5A5);
    check("uni_c2_src", src_of(2), 0);
    check("uni_c2_rdy", rdy(), 'b0001);
    step();
    check("uni_c3_rdy", rdy(), 0);
    check("uni_c3_ov", ov(), 0);
    drain();

    // Contention on output 0
    post(0, 4'b0001, 16'h1000);
    post(1, 4'b0001, 16'h1001);
    post(3, 4'b0001, 16'h1003);
    step();
    idle_inputs();
    step();
    check("con_c2_ov", ov(), 'b0001);
    check("con_c2_src", src_of(0), 0);
    check("con_c2_data", data_of(0), 'h1000);
    check("con_c2_rdy", rdy(), 'b0001);
    step();
    check("con_c3_src", src_of(0), 1);
    check("con_c3_data", data_of(0), 'h1001);
    check("con_c3_rdy", rdy(), 'b0010);
    step();
    check("con_c4_src", src_of(0), 3);
    check("con_c4_data", data_of(0), 'h1003);
    check("con_c4_rdy", rdy(), 'b1000);
    step();
    check("con_c5_ov", ov(), 0);
    drain();

    // Backpressure on output 1
    out_ready = 4'b1101;
    post(0, 4'b0010, 16'h2220);
    post(1, 4'b0010, 16'h2221);
    step();
    idle_inputs();
    step();
    check("bp_c2_rdy", rdy(), 'b0001);
    for (int c = 2; c <= 6; c++) begin
      check("bp_hold_ov", 32'(out_valid[1]), 1);
      check("bp_hold_src", src_of(1), 0);
      check("bp_hold_data", data_of(1), 'h2220);
      step();
    end
    check("bp_c7_src", src_of(1), 0);
    out_ready = '1;
    step();
    check("bp_c8_ov", ov(), 'b0010);
    check("bp_c8_src", src_of(1), 1);
    check("bp_c8_data", data_of(1), 'h2221);
    check("bp_c8_rdy", rdy(), 'b0010);
    drain();

    // Multicast (reduced to lowest output when multicast is disabled)
    post(3, 4'b0111, 16'h1234);
    step();
    idle_inputs();
    check("mc_c1_rdy", rdy(), 0);
    step();
    check("mc_c2_ov", ov(), MC ? 'b0111 : 'b0001);
    check("mc_c2_src0", src_of(0), 3);
    check("mc_c2_data0", data_of(0), 'h1234);
    for (int j = 1; j < 3; j++) begin
      if (out_valid[j]) check("mc_c2_srcj", src_of(j), 3);
    end
    check("mc_c2_rdy", rdy(), 'b1000);
    step();
    check("mc_c3_rdy", rdy(), 0);
    drain();

    // Zero mask
    post(2, 4'b0000, 16'hBEEF);
    step();
    idle_inputs();
    check("zm_c1_rdy", rdy(), 'b0100);
    check("zm_c1_ov", ov(), 0);
    step();
    check("zm_c2_rdy", rdy(), 0);
    check("zm_c2_ov", ov(), 0);
    drain();

    // Asynchronous reset with full slots, then fresh 4-way contention
    out_ready = '0;
    post(1, 4'b1111, 16'h7777);
    post(2, 4'b0001, 16'h8888);
    step();
    idle_inputs();
    step();
    check("rm_pre_ov", ov(), MC ? 'b1111 : 'b0001);
    check("rm_pre_src", src_of(0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_ov", ov(), 0);
    check("rm_async_rdy", rdy(), 0);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = '1;
    for (int i = 0; i < N; i++) post(i, 4'b0001, 16'(16'h3000 + i));
    step();
    idle_inputs();
    step();
    for (int i = 0; i < N; i++) begin
      check("rm_rr_src", src_of(0), i);
      check("rm_rr_data", data_of(0), 'h3000 + i);
      step();
    end
    check("rm_end_ov", ov(), 0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_compare();
      for (int i = 0; i < N; i++) begin
        req_valid[i]         = ($urandom_range(1) == 1);
        req_target[i*N +: N] = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
        req_data[i*DW +: DW] = 16'($urandom);
        out_ready[i]         = ($urandom_range(3) != 0);
      end
      model_step();
      step();
    end
    model_compare();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xbar_arbiter.md
XBAR_ARBITER -- requirements
Module: xbar_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of input and output ports; legal range 2..16.
REQ-002 Parameter DATA_W, default 16, payload width in bits.
REQ-003 Localparam PTR_W = $clog2(NUM_PORTS), source-index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  NUM_PORTS  bit i: input i presents a request.
REQ-007 req_target  input  NUM_PORTS*NUM_PORTS  slice [i*NUM_PORTS +: NUM_PORTS] is the target-output mask of input i.
REQ-008 req_data  input  NUM_PORTS*DATA_W  slice [i*DATA_W +: DATA_W] is the payload of input i.
REQ-009 req_ready  output  NUM_PORTS  bit i: one-cycle pulse, the request of input i is fully delivered.
REQ-010 out_valid  output  NUM_PORTS  bit j: output slot j holds a payload.
REQ-011 out_data  output  NUM_PORTS*DATA_W  payload of output slot j.
REQ-012 out_src  output  NUM_PORTS*PTR_W  index of the input that produced slot j.
REQ-013 out_ready  input  NUM_PORTS  bit j: the sink consumes slot j this cycle.

Function
REQ-014 Each input runs a three-state FSM: IN_IDLE, IN_ACTIVE, IN_DONE.
REQ-015 In IN_IDLE with req_valid[i]=1, the edge SHALL capture the target mask into pending[i] and req_data into a per-input data register, then move to IN_ACTIVE; a zero mask moves directly to IN_DONE.
REQ-016 req_valid, req_target and req_data SHALL be ignored outside IN_IDLE, so an input may change them after the capture edge.
REQ-017 Output slot j is free when out_valid[j]=0 or out_ready[j]=1.
REQ-018 When slot j is free, it arbitrates among inputs in IN_ACTIVE with pending[i][j]=1, round-robin, starting at rr_ptr[j]+1 modulo NUM_PORTS.
REQ-019 On a win, the edge SHALL load slot j (out_valid=1, data, src), clear pending[winner][j], and set rr_ptr[j] to the winner.
REQ-020 With candidates, a consumed slot SHALL be reloaded on the same edge, giving back-to-back delivery with no bubble.
REQ-021 With no candidates, a consumed slot SHALL clear out_valid[j].
REQ-022 While out_ready[j]=0 and out_valid[j]=1, slot j SHALL hold all its values, and rr_ptr[j] SHALL NOT change.
REQ-023 Several outputs may grant the same input on one edge, each clearing only its own pending bit.
REQ-024 When the last pending bit of input i clears, input i SHALL enter IN_DONE for exactly one cycle with req_ready[i]=1, then return to IN_IDLE.
REQ-025 Latency: request valid in cycle 0 gives out_valid in cycle 2 at the earliest, with req_ready in the same cycle 2 for a single-target request.
REQ-026 A zero-mask request SHALL give req_ready in cycle 1 and no output.

Reset
REQ-027 While rst_n=0: all FSMs in IN_IDLE, pending=0, req_ready=0, out_valid=0, out_data=0, out_src=0, rr_ptr[j]=NUM_PORTS-1 (so input 0 has first priority).
REQ-028 Reset asserted mid-operation SHALL discard all pending requests and slot contents immediately, without waiting for clk.

Configuration
REQ-029 Macro XBAR_MULTICAST_EN defined: the full captured mask is served (multicast).
REQ-030 Macro XBAR_MULTICAST_EN undefined: the captured mask is reduced to its lowest set bit, so each request delivers exactly one output.

Structure
REQ-031 Package xbar_pkg SHALL hold the in_state_e typedef and the NUM_PORTS/DATA_W default constants.
REQ-032 Sub-module rr_arbiter (NUM_PORTS-wide request vector plus pointer in, one-hot grant plus index out, combinational) SHALL be instantiated once per output.

Verification (NUM_PORTS=4, DATA_W=16)
REQ-033 Unicast: in0 target 4'b0100, data 16'hA5A5, cycle 0 -> out_valid[2]=1, out_data=16'hA5A5, out_src=0 in cycle 2; req_ready[0]=1 in cycle 2 only.
REQ-034 Contention: in0, in1, in3 all target 4'b0001 in cycle 0, out_ready=1 -> output 0 delivers src 0, 1, 3 in cycles 2, 3, 4.
REQ-035 Backpressure: in0 and in1 target 4'b0010, out_ready[1]=0 for cycles 0-6 -> slot 1 holds src 0 from cycle 2 to 6; src 1 appears in cycle 8 after out_ready[1]=1 in cycle 7; req_ready[1]=1 in cycle 8.
REQ-036 Multicast: in3 target 4'b0111, data 16'h1234 -> outputs 0, 1 and 2 valid in cycle 2 with src 3; single req_ready[3] pulse in cycle 2; with XBAR_MULTICAST_EN undefined, only output 0 is loaded.
REQ-037 Zero mask: in2 target 4'b0000 -> req_ready[2]=1 in cycle 1; out_valid stays 0.
REQ-038 Reset mid-op: rst_n=0 while slots are valid -> out_valid=0 with no clock edge; after release, a 4-way contention on output 0 grants input 0 first.
